rect_plotter: RTL and testbench
===============================

RECT_PLOTTER -- requirements
Module: rect_plotter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible height in pixels.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port x0  input  8  rectangle left column.
REQ-007 SHALL have port y0  input  7  rectangle top row.
REQ-008 SHALL have port w  input  5  rectangle width in pixels, 0..31.
REQ-009 SHALL have port h  input  4  rectangle height in pixels, 0..15.
REQ-010 SHALL have port colour  input  3  fill colour.
REQ-011 SHALL have port erase  input  1  when set at start, fill with background 3'b000 instead of colour.
REQ-012 SHALL have port stall  input  1  freeze the sweep this cycle.
REQ-013 SHALL have port x_out  output  8  pixel column to the VGA adapter.
REQ-014 SHALL have port y_out  output  7  pixel row to the VGA adapter.
REQ-015 SHALL have port colour_out  output  3  pixel colour.
REQ-016 SHALL have port plot  output  1  pixel write strobe.
REQ-017 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, SWEEP, FINISH.
REQ-020 In IDLE with start=1, SHALL latch x0, y0, w, h, and effective colour (erase ? 3'b000 : colour); clear cx, cy; go to SWEEP, or to FINISH if w==0 or h==0.
REQ-021 start in SWEEP or FINISH SHALL be ignored, with no effect on latched values.
REQ-022 In SWEEP with stall=0, SHALL present pixel (x0+cx, y0+cy) combinationally from registers, with cx incrementing fastest and cx wrapping to 0 with cy+1 after cx==w-1.
REQ-023 In SWEEP with stall=1, SHALL hold cx, cy, and state, and drive plot=0.
REQ-024 After the pixel cx==w-1, cy==h-1 is emitted, SHALL go to FINISH.
REQ-025 FINISH SHALL last exactly one cycle with done=1, then return to IDLE; a start that cycle is ignored.
REQ-026 Latency: with no stall, done SHALL assert exactly w*h+1 cycles after the accepted start edge; for w or h of 0, SHALL assert 1 cycle after.
REQ-027 Coordinate sums SHALL be computed 9-bit (x) and 8-bit (y); a pixel with x>=SCREEN_W or y>=SCREEN_H SHALL still consume its cycle with plot=0 (clipping, no wrap).
REQ-028 plot SHALL be 1 only in SWEEP with stall=0 and the pixel unclipped.
REQ-029 x_out and y_out SHALL be the truncated sums; colour_out SHALL be the latched effective colour.
REQ-030 busy SHALL equal (state != IDLE).
REQ-031 Each rectangle SHALL emit at most one plot per pixel, in raster order.

Reset
REQ-032 resetn=0 at a clk edge SHALL force IDLE, cx=cy=0, latched registers=0, plot=0, busy=0, done=0, x_out=0, y_out=0, colour_out=0.
REQ-033 Reset mid-SWEEP SHALL abandon the rectangle with no done pulse; plot SHALL be 0 from the first reset cycle.

Structure
REQ-034 Shared package SHALL hold SCREEN_W, SCREEN_H, coordinate widths (8/7), colour width 3, and COLOUR_BG=3'b000.
REQ-035 The cx/cy raster counter SHALL be one sub-module, raster_counter (inputs: clear, enable, w, h; outputs: cx, cy, last).
REQ-036 Ball and paddle datapaths SHALL each drive one rect_plotter instance ahead of the existing draw arbitration.

Verification
REQ-037 x0=10, y0=20, w=3, h=2, colour=3'b100, no stall -> plots (10,20) (11,20) (12,20) (10,21) (11,21) (12,21) colour 100; done 7 cycles after start.
REQ-038 x0=158, y0=119, w=4, h=2 -> only (158,119) and (159,119) plotted; 8 SWEEP cycles; done 9 cycles after start.
REQ-039 w=0, h=5 -> no plot, done 1 cycle after start; start while busy during a 4x4 rectangle -> ignored, single done pulse.
REQ-040 2x2 rectangle with stall high for 3 cycles after the first pixel -> same 4 pixels, plot=0 during stall, done 8 cycles after start.
REQ-041 erase=1, colour=3'b111 -> all pixels colour_out 000; resetn low mid-sweep -> plot=0, busy=0, no done pulse.

Source files
------------

// File: rtl/rect_plotter_pkg.sv
// Shared constants and types for the rectangle plotter: screen size, coordinate
// and colour widths, background colour and FSM state encoding.
package rect_plotter_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned XW       = 8;
    localparam int unsigned YW       = 7;
    localparam int unsigned CW       = 3;

    localparam logic [CW-1:0] COLOUR_BG = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StFinish
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order cx/cy counter for a w x h rectangle; cx runs fastest and
// wraps to 0 with cy+1 after cx == w-1.
module raster_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    input  logic [4:0] w,
    input  logic [3:0] h,
    output logic [4:0] cx,
    output logic [3:0] cy,
    output logic       last
);

    logic [4:0] cx_q, cx_d;
    logic [3:0] cy_q, cy_d;
    logic       row_end;

    assign row_end = (cx_q == w - 5'd1);
    assign last    = row_end && (cy_q == h - 4'd1);
    assign cx      = cx_q;
    assign cy      = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (enable) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = cy_q + 4'd1;
            end else begin
                cx_d = cx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Sweeps a filled rectangle one pixel per unstalled cycle in raster order,
// clipping pixels that fall off the visible screen.
module rect_plotter #(
    parameter int unsigned SCREEN_W = rect_plotter_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = rect_plotter_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [4:0] w,
    input  logic [3:0] h,
    input  logic [2:0] colour,
    input  logic       erase,
    input  logic       stall,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import rect_plotter_pkg::*;

    localparam logic [XW:0] XLim = SCREEN_W[XW:0];
    localparam logic [YW:0] YLim = SCREEN_H[YW:0];

    state_e state_q, state_d;
    logic   load;

    logic [XW-1:0] x0_q;
    logic [YW-1:0] y0_q;
    logic [4:0]    w_q;
    logic [3:0]    h_q;
    logic [CW-1:0] colour_q;

    logic [4:0]  cx;
    logic [3:0]  cy;
    logic        last;
    logic        sweep_en;
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;
    logic        clipped;

    assign sweep_en = (state_q == StSweep) && !stall;

    raster_counter u_raster_counter (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_q == StIdle),
        .enable (sweep_en),
        .w      (w_q),
        .h      (h_q),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (w == 5'd0 || h == 4'd0) ? StFinish : StSweep;
                end
            end
            StSweep:  if (sweep_en && last) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                x0_q     <= x0;
                y0_q     <= y0;
                w_q      <= w;
                h_q      <= h;
                colour_q <= erase ? COLOUR_BG : colour;
            end
        end
    end

    // Extra MSB keeps off-screen sums from wrapping back onto the screen.
    assign x_sum   = {1'b0, x0_q} + {4'b0, cx};
    assign y_sum   = {1'b0, y0_q} + {4'b0, cy};
    assign clipped = (x_sum >= XLim) || (y_sum >= YLim);

    assign x_out      = x_sum[XW-1:0];
    assign y_out      = y_sum[YW-1:0];
    assign colour_out = colour_q;
    // Gated by resetn so a reset cycle never writes a pixel or signals completion.
    assign plot       = resetn && sweep_en && !clipped;
    assign done       = resetn && (state_q == StFinish);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: the driver pushes expected pixels and done
// times from a plain loop model; a negedge monitor pops and compares.
module tb_rect_plotter;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [4:0] w = '0;
    logic [3:0] h = '0;
    logic [2:0] colour = '0;
    logic       erase = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    pix_t exp_pix[$];
    int   exp_done[$];

    rect_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .colour     (colour),
        .erase      (erase),
        .stall      (stall),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a pixel or done.
    always @(negedge clk) begin
        if (resetn) begin
            if (stall && busy) chk("plot_during_stall", 32'(plot), 32'd0);
            if (plot) begin
                if (exp_pix.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d required no plot", x_out, y_out);
                end else begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    chk("pixel_x", 32'(x_out), 32'(p.x));
                    chk("pixel_y", 32'(y_out), 32'(p.y));
                    chk("pixel_colour", 32'(colour_out), 32'(p.c));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d required none", cyc);
                end else begin
                    int d;
                    d = exp_done.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d));
                    chk("pixels_left_at_done", 32'(exp_pix.size()), 32'd0);
                end
            end
        end
    end

    task automatic push_pixels(input int x, input int y, input int ww, input int hh,
                               input logic [2:0] col, input bit er);
        for (int r = 0; r < hh; r++) begin
            for (int c = 0; c < ww; c++) begin
                if (x + c < 160 && y + r < 120) begin
                    pix_t p;
                    p.x = 8'(x + c);
                    p.y = 7'(y + r);
                    p.c = er ? 3'b000 : col;
                    exp_pix.push_back(p);
                end
            end
        end
    endtask

    // Entered and left at #1 after a posedge with the DUT idle.
    // stall_mode: 0 none, 1 random, 2 three cycles right after the first pixel.
    task automatic run_rect(input int x, input int y, input int ww, input int hh,
                            input logic [2:0] col, input bit er, input int stall_mode,
                            input bit garble);
        int c0;
        int n;
        int consumed;
        int k;
        bit st;
        x0 = 8'(x);
        y0 = 7'(y);
        w = 5'(ww);
        h = 4'(hh);
        colour = col;
        erase = er;
        start = 1'b1;
        stall = 1'b0;
        push_pixels(x, y, ww, hh, col, er);
        @(posedge clk);
        #1;
        c0 = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = ww * hh;
        consumed = 0;
        k = 1;
        if (n == 0) exp_done.push_back(c0);
        while (consumed < n) begin
            case (stall_mode)
                1: st = ($urandom_range(0, 3) == 0);
                2: st = (k >= 2 && k <= 4);
                default: st = 1'b0;
            endcase
            stall = st;
            start = garble ? 1'($urandom) : 1'b0;
            if (garble) begin
                x0 = 8'($urandom);
                y0 = 7'($urandom);
                w = 5'($urandom);
                h = 4'($urandom);
                colour = 3'($urandom);
                erase = 1'($urandom);
            end
            if (!st) consumed++;
            if (consumed == n) exp_done.push_back(c0 + k);
            @(posedge clk);
            #1;
            k++;
        end
        // Completion cycle: a start here must be ignored.
        stall = 1'($urandom);
        start = garble;
        @(posedge clk);
        #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_colour_out", 32'(colour_out), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_rect(10, 20, 3, 2, 3'b100, 1'b0, 0, 1'b0);
        run_rect(158, 119, 4, 2, 3'b010, 1'b0, 0, 1'b0);
        run_rect(5, 5, 0, 5, 3'b011, 1'b0, 0, 1'b0);
        run_rect(5, 5, 7, 0, 3'b011, 1'b0, 0, 1'b1);
        run_rect(40, 60, 4, 4, 3'b101, 1'b0, 0, 1'b1);
        run_rect(70, 80, 2, 2, 3'b110, 1'b0, 2, 1'b0);
        run_rect(30, 40, 3, 3, 3'b111, 1'b1, 0, 1'b0);
        run_rect(255, 127, 31, 15, 3'b001, 1'b0, 1, 1'b0);

        // Reset in the middle of a sweep abandons the rectangle silently.
        x0 = 8'd50;
        y0 = 7'd50;
        w = 5'd8;
        h = 4'd4;
        colour = 3'b101;
        erase = 1'b0;
        start = 1'b1;
        push_pixels(50, 50, 8, 4, 3'b101, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        exp_pix.delete();
        exp_done.delete();
        #2;
        chk("plot_first_reset_cycle", 32'(plot), 32'd0);
        chk("done_first_reset_cycle", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_reset_outputs();
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_after_reset_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 30; i++) begin
            run_rect($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 31),
                     $urandom_range(0, 15), 3'($urandom), 1'($urandom),
                     $urandom_range(0, 1), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pixels_left_at_end", 32'(exp_pix.size()), 32'd0);
        chk("dones_left_at_end", 32'(exp_done.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
